// File: rtl/seg_onoff_decoder.sv
// Recovers the ON/OFF status shown on three 7-segment displays, with a glitch filter and a change-event handshake.
// Commit latency is STABLE_CYCLES+1 edges from the first stable sample; a pending event is held until event_ready.
module seg_onoff_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg1,
    input  logic [6:0]  seg2,
    input  logic [6:0]  seg3,
    output logic        state_valid,
    output logic        state_on,
    output logic        state_err,
    output logic        event_valid,
    input  logic        event_ready,
    output logic        event_on,
    output logic        overrun,
    output logic [15:0] change_count
);

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_ON    = 3'd1,
        CLS_OFF   = 3'd2,
        CLS_BLANK = 3'd3,
        CLS_BAD   = 3'd4
    } cls_t;

    localparam logic [7:0]  STABLE    = 8'(STABLE_CYCLES);
    // Patterns are {seg3, seg2, seg1}: "On " and "OFF" read left to right.
    localparam logic [20:0] PAT_ON    = {7'b1000000, 7'b0101011, 7'b1111111};
    localparam logic [20:0] PAT_OFF   = {7'b1000000, 7'b0001110, 7'b0001110};
    localparam logic [20:0] PAT_BLANK = {7'b1111111, 7'b1111111, 7'b1111111};

    cls_t        dec;
    cls_t        cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    cls_t        committed_q, committed_d;
    logic        last_rep_q, last_rep_d;
    logic        seen_q, seen_d;
    logic        state_valid_q, state_valid_d;
    logic        state_on_q, state_on_d;
    logic        state_err_q, state_err_d;
    logic        event_valid_q, event_valid_d;
    logic        event_on_q, event_on_d;
    logic        overrun_q, overrun_d;
    logic [15:0] change_count_q, change_count_d;
    logic        commit_onoff;
    logic        commit_val;
    logic        new_evt;

    always_comb begin
        unique case ({seg3, seg2, seg1})
            PAT_ON:    dec = CLS_ON;
            PAT_OFF:   dec = CLS_OFF;
            PAT_BLANK: dec = CLS_BLANK;
            default:   dec = CLS_BAD;
        endcase
    end

    always_comb begin
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        committed_d    = committed_q;
        last_rep_d     = last_rep_q;
        seen_d         = seen_q;
        event_valid_d  = event_valid_q;
        event_on_d     = event_on_q;
        overrun_d      = overrun_q;
        change_count_d = change_count_q;

        if (dec != cand_q) begin
            cand_d = dec;
            cnt_d  = 8'd1;
        end else if (cnt_q < STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (cnt_q == STABLE) begin
            committed_d = cand_q;
        end

        commit_onoff = (committed_d == CLS_ON) || (committed_d == CLS_OFF);
        commit_val   = (committed_d == CLS_ON);
        // Only a fresh commit of a value different from the last report is an event;
        // bouncing through BLANK/BAD back to the same value stays silent.
        new_evt      = commit_onoff && (committed_d != committed_q) &&
                       (!seen_q || (commit_val != last_rep_q));

        if (new_evt) begin
            last_rep_d    = commit_val;
            seen_d        = 1'b1;
            event_valid_d = 1'b1;
            event_on_d    = commit_val;
            if (event_valid_q && !event_ready) begin
                overrun_d = 1'b1;
            end
            if (seen_q && (change_count_q != 16'hFFFF)) begin
                change_count_d = change_count_q + 16'd1;
            end
        end else if (event_valid_q && event_ready) begin
            event_valid_d = 1'b0;
        end

        state_valid_d = commit_onoff;
        state_on_d    = (committed_d == CLS_ON);
        state_err_d   = (committed_d == CLS_BAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q         <= CLS_NONE;
            cnt_q          <= 8'd0;
            committed_q    <= CLS_NONE;
            last_rep_q     <= 1'b0;
            seen_q         <= 1'b0;
            state_valid_q  <= 1'b0;
            state_on_q     <= 1'b0;
            state_err_q    <= 1'b0;
            event_valid_q  <= 1'b0;
            event_on_q     <= 1'b0;
            overrun_q      <= 1'b0;
            change_count_q <= 16'd0;
        end else begin
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            committed_q    <= committed_d;
            last_rep_q     <= last_rep_d;
            seen_q         <= seen_d;
            state_valid_q  <= state_valid_d;
            state_on_q     <= state_on_d;
            state_err_q    <= state_err_d;
            event_valid_q  <= event_valid_d;
            event_on_q     <= event_on_d;
            overrun_q      <= overrun_d;
            change_count_q <= change_count_d;
        end
    end

    assign state_valid  = state_valid_q;
    assign state_on     = state_on_q;
    assign state_err    = state_err_q;
    assign event_valid  = event_valid_q;
    assign event_on     = event_on_q;
    assign overrun      = overrun_q;
    assign change_count = change_count_q;

endmodule
